// File: rtl/cim_pkg.sv
// Shared types and constants for the CIM matrix-vector sequencer slice.
package cim_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        ACCUM = 2'd2,
        DRAIN = 2'd3
    } cim_state_t;

    localparam int CIM_NUM_OUT = 8;
    localparam int CIM_COL_W   = 7;
    localparam int CIM_ADDR_W  = 10;

endpackage

// File: rtl/cim_res_shaper.sv
// Result shaping stage between the macro output and the result stream.
// Build option CIM_RELU_EN clamps negative accumulations to zero; otherwise pass-through.
module cim_res_shaper (
    input  logic [31:0] rdata,
    output logic [31:0] res_data
);

`ifdef CIM_RELU_EN
    assign res_data = rdata[31] ? 32'd0 : rdata;
`else
    assign res_data = rdata;
`endif

endmodule

// File: rtl/cim_mvm_sequencer.sv
// Sequences the CIM macro through clear / accumulate / drain for one MVM job,
// and forwards host weight writes while idle. Optional ReLU via CIM_RELU_EN.
module cim_mvm_sequencer
    import cim_pkg::*;
#(
    parameter int LEN_W   = 5,
    parameter int COL_W   = CIM_COL_W,
    parameter int NUM_OUT = CIM_NUM_OUT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [CIM_ADDR_W-1:0] wr_addr,
    input  logic [31:0]           wr_data,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [COL_W-1:0]      cmd_col,
    input  logic [LEN_W-1:0]      cmd_len,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_data,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [31:0]           res_data,
    output logic [2:0]            res_idx,
    output logic                  res_last,
    output logic                  busy,
    output logic                  cim_cs,
    output logic                  cim_write,
    output logic                  cim_en,
    output logic                  cim_partial_sum,
    output logic                  cim_reset_output,
    output logic [3:0]            cim_output_reg,
    output logic [31:0]           cim_address,
    output logic [31:0]           cim_input_data,
    input  logic [31:0]           cim_rdata
);

    localparam int IDX_W = $clog2(NUM_OUT);

    cim_state_t        state_reg;
    logic [COL_W-1:0]  col_reg;
    logic [LEN_W-1:0]  len_reg;
    logic [LEN_W-1:0]  k_reg;
    logic [IDX_W-1:0]  j_reg;

    logic              last_chunk;
    logic              last_idx;
    logic [COL_W-1:0]  step_col;
    logic [31:0]       shaped_data;

    assign last_chunk = (k_reg == (len_reg - {{(LEN_W-1){1'b0}}, 1'b1}));
    assign last_idx   = (j_reg == IDX_W'(NUM_OUT - 1));
    // Each chunk covers eight columns; the offset wraps inside the bank.
    assign step_col   = col_reg + COL_W'({k_reg, 3'b000});

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            col_reg   <= '0;
            len_reg   <= '0;
            k_reg     <= '0;
            j_reg     <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (!wr_valid && cmd_valid) begin
                        col_reg   <= cmd_col;
                        len_reg   <= cmd_len;
                        k_reg     <= '0;
                        j_reg     <= '0;
                        state_reg <= CLEAR;
                    end
                end
                CLEAR: begin
                    state_reg <= (len_reg != '0) ? ACCUM : DRAIN;
                end
                ACCUM: begin
                    if (in_valid) begin
                        k_reg <= k_reg + 1'b1;
                        if (last_chunk) state_reg <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (res_ready) begin
                        if (last_idx) begin
                            j_reg     <= '0;
                            state_reg <= IDLE;
                        end else begin
                            j_reg <= j_reg + 1'b1;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    cim_res_shaper u_shaper (
        .rdata    (cim_rdata),
        .res_data (shaped_data)
    );

    always_comb begin
        wr_ready         = 1'b0;
        cmd_ready        = 1'b0;
        in_ready         = 1'b0;
        res_valid        = 1'b0;
        res_data         = 32'd0;
        res_idx          = 3'd0;
        res_last         = 1'b0;
        busy             = (state_reg != IDLE);
        cim_cs           = 1'b0;
        cim_write        = 1'b0;
        cim_en           = 1'b0;
        cim_partial_sum  = 1'b0;
        cim_reset_output = 1'b0;
        cim_output_reg   = 4'd0;
        cim_address      = 32'd0;
        cim_input_data   = 32'd0;
        case (state_reg)
            IDLE: begin
                wr_ready  = 1'b1;
                cmd_ready = !wr_valid;
                if (wr_valid) begin
                    cim_cs         = 1'b1;
                    cim_write      = 1'b1;
                    cim_address    = {{(32-CIM_ADDR_W){1'b0}}, wr_addr};
                    cim_input_data = wr_data;
                end
            end
            CLEAR: begin
                cim_cs           = 1'b1;
                cim_en           = 1'b1;
                cim_reset_output = 1'b1;
            end
            ACCUM: begin
                in_ready        = 1'b1;
                cim_en          = 1'b1;
                cim_partial_sum = 1'b1;
                cim_cs          = in_valid;
                cim_address     = {{(32-COL_W){1'b0}}, step_col};
                cim_input_data  = in_data;
            end
            DRAIN: begin
                cim_en         = 1'b1;
                cim_output_reg = 4'(j_reg);
                res_valid      = 1'b1;
                res_data       = shaped_data;
                res_idx        = 3'(j_reg);
                res_last       = last_idx;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cim_mvm_sequencer.sv
// Scoreboard bench: stimulus pushes expected macro commits and results; negedge monitors compare.
module tb_cim_mvm_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_valid, wr_ready;
    logic [9:0]  wr_addr;
    logic [31:0] wr_data;
    logic        cmd_valid, cmd_ready;
    logic [6:0]  cmd_col;
    logic [4:0]  cmd_len;
    logic        in_valid, in_ready;
    logic [31:0] in_data;
    logic        res_valid, res_ready;
    logic [31:0] res_data;
    logic [2:0]  res_idx;
    logic        res_last, busy;
    logic        cim_cs, cim_write, cim_en, cim_partial_sum, cim_reset_output;
    logic [3:0]  cim_output_reg;
    logic [31:0] cim_address, cim_input_data, cim_rdata;

    logic [31:0] rdata_tbl [0:15];
    assign cim_rdata = rdata_tbl[cim_output_reg];

    always #5 clk = ~clk;

    cim_mvm_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_col(cmd_col), .cmd_len(cmd_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_idx(res_idx), .res_last(res_last), .busy(busy),
        .cim_cs(cim_cs), .cim_write(cim_write), .cim_en(cim_en),
        .cim_partial_sum(cim_partial_sum), .cim_reset_output(cim_reset_output),
        .cim_output_reg(cim_output_reg), .cim_address(cim_address),
        .cim_input_data(cim_input_data), .cim_rdata(cim_rdata)
    );

    typedef struct {
        logic        wr, en, ps, ro;
        logic [31:0] addr, data;
        bit          chk_ad;
    } mac_t;

    typedef struct {
        logic [31:0] data;
        logic [2:0]  idx;
        logic        last;
    } res_t;

    mac_t mac_q[$];
    res_t res_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] shape(input logic [31:0] x);
`ifdef CIM_RELU_EN
        return x[31] ? 32'd0 : x;
`else
        return x;
`endif
    endfunction

    // Macro commit monitor
    always @(negedge clk) begin
        if (rst_n && cim_cs) begin
            if (mac_q.size() == 0) begin
                chk("mac_unexpected_cs", 32'd1, 32'd0);
            end else begin
                mac_t e;
                e = mac_q.pop_front();
                chk("mac_write", {31'd0, cim_write}, {31'd0, e.wr});
                chk("mac_en", {31'd0, cim_en}, {31'd0, e.en});
                chk("mac_psum", {31'd0, cim_partial_sum}, {31'd0, e.ps});
                chk("mac_rstout", {31'd0, cim_reset_output}, {31'd0, e.ro});
                if (e.chk_ad) begin
                    chk("mac_addr", cim_address, e.addr);
                    chk("mac_data", cim_input_data, e.data);
                end
            end
        end
    end

    // Result stream monitor
    always @(negedge clk) begin
        if (rst_n && res_valid && res_ready) begin
            if (res_q.size() == 0) begin
                chk("res_unexpected", 32'd1, 32'd0);
            end else begin
                res_t r;
                r = res_q.pop_front();
                chk("res_data", res_data, r.data);
                chk("res_idx", {29'd0, res_idx}, {29'd0, r.idx});
                chk("res_last", {31'd0, res_last}, {31'd0, r.last});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [9:0] a, input logic [31:0] d);
        mac_q.push_back('{wr:1'b1, en:1'b0, ps:1'b0, ro:1'b0, addr:{22'd0, a}, data:d, chk_ad:1'b1});
        wr_valid = 1'b1; wr_addr = a; wr_data = d;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (wr_ready) break;
            if (n == 99) chk("wr_timeout", 32'd1, 32'd0);
        end
        step();
        wr_valid = 1'b0;
    endtask

    task automatic do_cmd(input logic [6:0] c, input logic [4:0] l);
        mac_q.push_back('{wr:1'b0, en:1'b1, ps:1'b0, ro:1'b1, addr:32'd0, data:32'd0, chk_ad:1'b0});
        cmd_valid = 1'b1; cmd_col = c; cmd_len = l;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (cmd_ready) break;
            if (n == 99) chk("cmd_timeout", 32'd1, 32'd0);
        end
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic do_chunk(input logic [31:0] d, input logic [31:0] exp_addr);
        mac_q.push_back('{wr:1'b0, en:1'b1, ps:1'b1, ro:1'b0, addr:exp_addr, data:d, chk_ad:1'b1});
        in_valid = 1'b1; in_data = d;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (in_ready) break;
            if (n == 99) chk("in_timeout", 32'd1, 32'd0);
        end
        step();
        in_valid = 1'b0;
    endtask

    task automatic push_results();
        for (int i = 0; i < 8; i++)
            res_q.push_back('{data:shape(rdata_tbl[i]), idx:3'(i), last:(i == 7)});
    endtask

    task automatic clear_tbl();
        for (int i = 0; i < 16; i++) rdata_tbl[i] = 32'd0;
    endtask

    task automatic wait_drain();
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (res_q.size() == 0 && !busy) break;
            if (n == 299) chk("drain_timeout", 32'd1, 32'd0);
        end
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        cmd_valid = 1'b0; cmd_col = '0; cmd_len = '0;
        in_valid = 1'b0; in_data = '0; res_ready = 1'b1;
        clear_tbl();
        repeat (3) step();
        @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_wr_ready", {31'd0, wr_ready}, 32'd1);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_cs", {31'd0, cim_cs}, 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // Job 1: one chunk, result 8 on idx0
        do_write(10'd0, 32'h40404040);
        do_write(10'd4, 32'h40404040);
        clear_tbl(); rdata_tbl[0] = 32'd8;
        do_cmd(7'd0, 5'd1);
        do_chunk(32'h44444444, 32'h0);
        push_results();
        wait_drain();
        $display("job1 done");

        // Job 2: two chunks with stall between, result stream held with res_ready low
        do_write(10'd8, 32'h40404040);
        do_write(10'd12, 32'h40404040);
        clear_tbl(); rdata_tbl[0] = 32'd16;
        res_ready = 1'b0;
        do_cmd(7'd0, 5'd2);
        do_chunk(32'h44444444, 32'h0);
        repeat (3) step();
        do_chunk(32'h44444444, 32'h8);
        push_results();
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            chk("hold_valid", {31'd0, res_valid}, 32'd1);
            chk("hold_idx", {29'd0, res_idx}, 32'd0);
            chk("hold_data", res_data, shape(32'd16));
        end
        step();
        res_ready = 1'b1;
        wait_drain();
        $display("job2 done");

        // Job 3: negative accumulation, ReLU-dependent
        do_write(10'd0, 32'hFFFFFFFF);
        do_write(10'd4, 32'hFFFFFFFF);
        clear_tbl(); rdata_tbl[0] = 32'hFFFFFFF7;
        do_cmd(7'd0, 5'd1);
        do_chunk(32'hFFFFFFFF, 32'h0);
        push_results();
        wait_drain();
        $display("job3 done");

        // Job 4: write and command together, write wins; len=0 drains zeros
        clear_tbl();
        mac_q.push_back('{wr:1'b1, en:1'b0, ps:1'b0, ro:1'b0, addr:32'h10, data:32'h01020304, chk_ad:1'b1});
        mac_q.push_back('{wr:1'b0, en:1'b1, ps:1'b0, ro:1'b1, addr:32'd0, data:32'd0, chk_ad:1'b0});
        wr_valid = 1'b1; wr_addr = 10'h10; wr_data = 32'h01020304;
        cmd_valid = 1'b1; cmd_col = 7'd0; cmd_len = 5'd0;
        @(negedge clk);
        chk("prio_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        chk("prio_wr_ready", {31'd0, wr_ready}, 32'd1);
        step();
        wr_valid = 1'b0;
        @(negedge clk);
        chk("prio_cmd_next", {31'd0, cmd_ready}, 32'd1);
        step();
        cmd_valid = 1'b0;
        push_results();
        wait_drain();
        $display("job4 done");

        // Job 5: column wrap 0x7C -> 0x04
        clear_tbl(); rdata_tbl[3] = 32'd5;
        do_cmd(7'h7C, 5'd2);
        do_chunk(32'h12345678, 32'h7C);
        do_chunk(32'h87654321, 32'h04);
        push_results();
        wait_drain();
        $display("job5 done");

        // Job 6: reset during ACCUM, then a fresh job
        do_cmd(7'd0, 5'd2);
        do_chunk(32'h11111111, 32'h0);
        rst_n = 1'b0;
        step();
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
        step();
        rst_n = 1'b1;
        clear_tbl(); rdata_tbl[0] = 32'd5;
        do_cmd(7'h10, 5'd1);
        do_chunk(32'h22222222, 32'h10);
        push_results();
        wait_drain();
        $display("job6 done");

        repeat (2) step();
        chk("mac_q_empty", mac_q.size(), 32'd0);
        chk("res_q_empty", res_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
